// File: rtl/taylor_pkg.sv
// Shared definitions for the taylor instruction-fetch slice: geometry defaults,
// the NOP word, MIPS-style opcode values and the fetch FSM state type.
package taylor_pkg;

  localparam int PC_W       = 10;
  localparam int IMEM_DEPTH = 1024;
  localparam int RESET_PC   = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // IDLE while reset is held, RUN once fetching has started.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_t;

  // Primary opcode field of an instruction word.
  function automatic logic [5:0] opcodeOf(input logic [31:0] word);
    return word[31:26];
  endfunction

endpackage

// File: rtl/taylor_fetch_if.sv
// Control, load and instruction-output bundle between the fetch stage and its
// surroundings. The master side drives control/load; the slave is the fetch unit.
interface taylor_fetch_if #(
  parameter int PC_W = taylor_pkg::PC_W
);

  logic            stall;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            load_en;
  logic [PC_W-1:0] load_addr;
  logic [31:0]     load_data;
  logic [PC_W-1:0] pc;
  logic            inst_valid;
  logic [31:0]     inst;
  logic [PC_W-1:0] inst_pc;
  logic [5:0]      opcode;

  modport master (
    output stall, redirect_valid, redirect_pc, load_en, load_addr, load_data,
    input  pc, inst_valid, inst, inst_pc, opcode
  );

  modport slave (
    input  stall, redirect_valid, redirect_pc, load_en, load_addr, load_data,
    output pc, inst_valid, inst, inst_pc, opcode
  );

endinterface

// File: rtl/taylor_imem.sv
// Instruction memory: one synchronous read port (1-cycle latency, registered
// output that reset clears to NOP) and one write port. Only the low address
// bits are used, so any address aliases into the array.
module taylor_imem
  import taylor_pkg::*;
#(
  parameter int PC_W  = taylor_pkg::PC_W,
  parameter int DEPTH = taylor_pkg::IMEM_DEPTH
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_rd_en,
  input  logic [PC_W-1:0] i_rd_addr,
  output logic [31:0]     o_rd_data,
  input  logic            i_wr_en,
  input  logic [PC_W-1:0] i_wr_addr,
  input  logic [31:0]     i_wr_data
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]       r_mem [DEPTH];
  logic [31:0]       r_rd_data;
  logic [ADDR_W-1:0] w_rd_idx;
  logic [ADDR_W-1:0] w_wr_idx;

  assign w_rd_idx  = ADDR_W'(i_rd_addr);
  assign w_wr_idx  = ADDR_W'(i_wr_addr);
  assign o_rd_data = r_rd_data;

  // Writes are honoured regardless of reset so software can be loaded while held.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[w_wr_idx] <= i_wr_data;
  end

  // Registered read; a same-edge write to the same word is seen only next time.
  always_ff @(posedge i_clk) begin
    if (i_rst)        r_rd_data <= NOP;
    else if (i_rd_en) r_rd_data <= r_mem[w_rd_idx];
  end

endmodule

// File: rtl/taylor_fetch.sv
// Fetch stage: owns the program counter and the valid/pc tag of the instruction
// word held by the memory read register. Redirects flush the slot and retarget
// pc; stalls freeze the slot for decode.
module taylor_fetch
  import taylor_pkg::*;
#(
  parameter int PC_W       = taylor_pkg::PC_W,
  parameter int IMEM_DEPTH = taylor_pkg::IMEM_DEPTH,
  parameter int RESET_PC   = taylor_pkg::RESET_PC
) (
  input logic           clk,
  input logic           rst,
  taylor_fetch_if.slave io_bus
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;
  logic [PC_W-1:0] r_inst_pc;
  logic [PC_W-1:0] w_inst_pc_next;
  logic            r_inst_valid;
  logic            w_inst_valid_next;
  logic            w_fetch;
  logic [31:0]     w_inst;

  taylor_imem #(
    .PC_W  (PC_W),
    .DEPTH (IMEM_DEPTH)
  ) u_imem (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_rd_en   (w_fetch),
    .i_rd_addr (r_pc),
    .o_rd_data (w_inst),
    .i_wr_en   (io_bus.load_en),
    .i_wr_addr (io_bus.load_addr),
    .i_wr_data (io_bus.load_data)
  );

  assign io_bus.pc         = r_pc;
  assign io_bus.inst_valid = r_inst_valid;
  assign io_bus.inst       = w_inst;
  assign io_bus.inst_pc    = r_inst_pc;
  assign io_bus.opcode     = opcodeOf(w_inst);

  // State register; reset drops any in-flight slot and coincident redirect/stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_pc         <= PC_W'(RESET_PC);
      r_inst_pc    <= PC_W'(RESET_PC);
      r_inst_valid <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_inst_pc    <= w_inst_pc_next;
      r_inst_valid <= w_inst_valid_next;
    end
  end

  // Next state: redirect beats stall beats fetch; leaving IDLE always fetches.
  always_comb begin
    w_state_next      = ST_RUN;
    w_pc_next         = r_pc;
    w_inst_pc_next    = r_inst_pc;
    w_inst_valid_next = r_inst_valid;
    w_fetch           = 1'b0;
    if (io_bus.redirect_valid) begin
      w_pc_next         = io_bus.redirect_pc;
      w_inst_valid_next = 1'b0;
    end else if (io_bus.stall && (r_state == ST_RUN)) begin
      w_fetch = 1'b0;
    end else begin
      w_fetch           = 1'b1;
      w_pc_next         = r_pc + PC_W'(1);
      w_inst_pc_next    = r_pc;
      w_inst_valid_next = 1'b1;
    end
  end

endmodule

// File: tb/tb_taylor_fetch.sv
// Testbench for taylor_fetch: a directed vector table for the reference program,
// stall, redirect, reset and read-before-write cases, randomized traffic against
// a behavioural model, and a second instance exercising pc wrap-around.
module tb_taylor_fetch;

  logic clk = 1'b0;
  logic rstA;
  logic rstB;

  always #5 clk = ~clk;

  taylor_fetch_if #(.PC_W(10)) busA ();
  taylor_fetch_if #(.PC_W(10)) busB ();

  taylor_fetch #(.PC_W(10), .IMEM_DEPTH(1024), .RESET_PC(0)) dutA (
    .clk    (clk),
    .rst    (rstA),
    .io_bus (busA)
  );

  taylor_fetch #(.PC_W(10), .IMEM_DEPTH(1024), .RESET_PC(1022)) dutB (
    .clk    (clk),
    .rst    (rstB),
    .io_bus (busB)
  );

  int compareCount = 0;
  int failCount    = 0;

  // Behavioural model of dutA: memory image plus the architectural outputs.
  logic [31:0] modelMem [1024];
  int          mPc;
  int          mInstPc;
  logic        mValid;
  logic [31:0] mInst;
  logic        mRun;
  logic        mShowInst;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [9:0]  rpc;
    logic        le;
    logic [9:0]  la;
    logic [31:0] ld;
    logic [9:0]  ePc;
    logic        eValid;
    logic [31:0] eInst;
    logic [9:0]  eInstPc;
    logic        chkInst;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mkVec(input logic r, input logic st, input logic rv,
                                 input logic [9:0] rpc, input logic le,
                                 input logic [9:0] la, input logic [31:0] ld,
                                 input logic [9:0] ePc, input logic eValid,
                                 input logic [31:0] eInst, input logic [9:0] eInstPc,
                                 input logic chk);
    vec_t v;
    v.rst = r; v.stall = st; v.rv = rv; v.rpc = rpc;
    v.le = le; v.la = la; v.ld = ld;
    v.ePc = ePc; v.eValid = eValid; v.eInst = eInst; v.eInstPc = eInstPc;
    v.chkInst = chk;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compareCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advances the model by one edge from the inputs currently driven on dutA.
  task automatic modelStep();
    logic [31:0] oldWord;
    oldWord = modelMem[mPc];
    if (rstA) begin
      mPc = 0; mInstPc = 0; mValid = 1'b0; mInst = 32'h0;
      mShowInst = 1'b1;
    end else if (busA.redirect_valid) begin
      mPc = int'(busA.redirect_pc);
      mValid = 1'b0;
      mShowInst = 1'b0;
    end else if (busA.stall && mRun) begin
      mPc = mPc;
    end else begin
      mInst = oldWord;
      mInstPc = mPc;
      mPc = (mPc + 1) % 1024;
      mValid = 1'b1;
      mShowInst = 1'b1;
    end
    mRun = !rstA;
    if (busA.load_en) modelMem[int'(busA.load_addr) % 1024] = busA.load_data;
  endtask

  task automatic applyStimulus(input logic r, input logic st, input logic rv,
                               input logic [9:0] rpc, input logic le,
                               input logic [9:0] la, input logic [31:0] ld);
    rstA = r;
    busA.stall = st;
    busA.redirect_valid = rv;
    busA.redirect_pc = rpc;
    busA.load_en = le;
    busA.load_addr = la;
    busA.load_data = ld;
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".pc"}, 32'(busA.pc), 32'(mPc));
    checkOutput({tag, ".valid"}, 32'(busA.inst_valid), 32'(mValid));
    if (mShowInst) begin
      checkOutput({tag, ".inst"}, busA.inst, mInst);
      checkOutput({tag, ".inst_pc"}, 32'(busA.inst_pc), 32'(mInstPc));
      checkOutput({tag, ".opcode"}, 32'(busA.opcode), 32'(mInst[31:26]));
    end
  endtask

  initial begin
    logic [31:0] pre [1024];
    logic [31:0] w;

    rstA = 1'b1; rstB = 1'b1;
    busA.stall = 0; busA.redirect_valid = 0; busA.redirect_pc = 0;
    busA.load_en = 0; busA.load_addr = 0; busA.load_data = 0;
    busB.stall = 0; busB.redirect_valid = 0; busB.redirect_pc = 0;
    busB.load_en = 0; busB.load_addr = 0; busB.load_data = 0;
    for (int i = 0; i < 1024; i++) modelMem[i] = 32'h0;
    mPc = 0; mInstPc = 0; mValid = 0; mInst = 0; mRun = 0; mShowInst = 1;

    for (int i = 0; i < 1024; i++) pre[i] = $urandom;
    pre[0] = 32'h20080005; pre[1] = 32'h20090003;
    pre[2] = 32'h01095020; pre[3] = 32'hAC0A0000;
    pre[4] = 32'h3C010001; pre[5] = 32'h8C0B0004;
    pre[100] = 32'h1109FFFD;

    @(posedge clk); #1;
    // Load the whole memory while reset is held.
    for (int i = 0; i < 1024; i++) applyStimulus(1, 0, 0, 0, 1, 10'(i), pre[i]);

    vecs[0]  = mkVec(1,0,0,  0,0,0,0,            0,0,32'h00000000,0,1);
    vecs[1]  = mkVec(0,0,0,  0,0,0,0,            1,1,32'h20080005,0,1);
    vecs[2]  = mkVec(0,0,0,  0,0,0,0,            2,1,32'h20090003,1,1);
    vecs[3]  = mkVec(0,0,0,  0,0,0,0,            3,1,32'h01095020,2,1);
    vecs[4]  = mkVec(0,1,0,  0,0,0,0,            3,1,32'h01095020,2,1);
    vecs[5]  = mkVec(0,1,0,  0,0,0,0,            3,1,32'h01095020,2,1);
    vecs[6]  = mkVec(0,1,0,  0,0,0,0,            3,1,32'h01095020,2,1);
    vecs[7]  = mkVec(0,0,0,  0,0,0,0,            4,1,32'hAC0A0000,3,1);
    vecs[8]  = mkVec(0,1,1,100,0,0,0,          100,0,32'h00000000,0,0);
    vecs[9]  = mkVec(0,0,0,  0,0,0,0,          101,1,32'h1109FFFD,100,1);
    vecs[10] = mkVec(1,0,1, 50,0,0,0,            0,0,32'h00000000,0,1);
    vecs[11] = mkVec(0,0,0,  0,0,0,0,            1,1,32'h20080005,0,1);
    vecs[12] = mkVec(0,0,0,  0,0,0,0,            2,1,32'h20090003,1,1);
    vecs[13] = mkVec(0,0,0,  0,0,0,0,            3,1,32'h01095020,2,1);
    vecs[14] = mkVec(0,0,0,  0,0,0,0,            4,1,32'hAC0A0000,3,1);
    vecs[15] = mkVec(0,0,0,  0,0,0,0,            5,1,32'h3C010001,4,1);
    vecs[16] = mkVec(0,0,0,  0,1,5,32'hDEADBEEF, 6,1,32'h8C0B0004,5,1);
    vecs[17] = mkVec(0,0,1,  5,0,0,0,            5,0,32'h00000000,0,0);
    vecs[18] = mkVec(0,0,0,  0,0,0,0,            6,1,32'hDEADBEEF,5,1);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].stall, vecs[i].rv, vecs[i].rpc,
                    vecs[i].le, vecs[i].la, vecs[i].ld);
      checkOutput($sformatf("vec%0d.pc", i), 32'(busA.pc), 32'(vecs[i].ePc));
      checkOutput($sformatf("vec%0d.valid", i), 32'(busA.inst_valid), 32'(vecs[i].eValid));
      if (vecs[i].chkInst) begin
        w = vecs[i].eInst;
        checkOutput($sformatf("vec%0d.inst", i), busA.inst, w);
        checkOutput($sformatf("vec%0d.inst_pc", i), 32'(busA.inst_pc), 32'(vecs[i].eInstPc));
        checkOutput($sformatf("vec%0d.opcode", i), 32'(busA.opcode), 32'(w[31:26]));
      end
    end

    // Randomized traffic with occasional reset, redirects, stalls and loads.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 7) == 0), 10'($urandom_range(0, 1023)),
                    ($urandom_range(0, 3) == 0), 10'($urandom_range(0, 1023)),
                    $urandom);
      checkModel($sformatf("rand%0d", i));
    end

    // Second instance: reset value and wrap-around from RESET_PC=1022.
    checkOutput("wrap.reset_pc", 32'(busB.pc), 32'd1022);
    checkOutput("wrap.reset_valid", 32'(busB.inst_valid), 32'd0);
    checkOutput("wrap.reset_inst_pc", 32'(busB.inst_pc), 32'd1022);
    checkOutput("wrap.reset_inst", busB.inst, 32'h0);
    rstB = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("wrap%0d.inst_pc", k), 32'(busB.inst_pc), 32'((1022 + k) % 1024));
      checkOutput($sformatf("wrap%0d.pc", k), 32'(busB.pc), 32'((1023 + k) % 1024));
      checkOutput($sformatf("wrap%0d.valid", k), 32'(busB.inst_valid), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
